// File: rtl/router_pkg.sv
// Shared defaults and helpers for the 1xN router synchroniser.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;
    localparam int ROUTER_TIMEOUT   = 30;
    localparam int ROUTER_MAX_PORTS = 8;

    // Decode addr to a one-hot port select; an address at or beyond n yields zero.
    function automatic logic [ROUTER_MAX_PORTS-1:0] onehot(input logic [7:0] addr, input int n);
        logic [ROUTER_MAX_PORTS-1:0] sel;
        sel = '0;
        if (32'(addr) < 32'(n) && 32'(addr) < 32'(ROUTER_MAX_PORTS)) begin
            sel[addr[2:0]] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_port_timer.sv
// Per-port unread-valid watchdog: one-cycle soft_reset after TIMEOUT_CYC unread valid cycles.
// Outputs are registered (one edge after the terminal count); no backpressure.
module router_port_timer #(
    parameter int TIMEOUT_CYC = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_i,
    input  logic rd_i,
    input  logic clr_i,
    output logic soft_reset_o,
    output logic status_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_q, soft_d;
    logic             stat_q, stat_d;

    // A timeout event on the same edge as a clear keeps the status bit set.
    always_comb begin
        cnt_d  = '0;
        soft_d = 1'b0;
        stat_d = stat_q & ~clr_i;
        if (!reset) begin
            stat_d = 1'b0;
        end else if (vld_i && !rd_i) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                soft_d = 1'b1;
                stat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        soft_q <= soft_d;
        stat_q <= stat_d;
    end

    assign soft_reset_o = soft_q;
    assign status_o     = stat_q;

endmodule

// File: rtl/router_sync_nport.sv
// N-port router synchroniser: latches destination, steers write enable, reports full/valid/timeouts.
// write_enb/fifo_full follow addr_q combinationally; writes are withheld from a full FIFO.
module router_sync_nport
    import router_pkg::*;
#(
    parameter int NUM_PORTS   = ROUTER_NUM_PORTS,
    parameter int ADDR_W      = ROUTER_ADDR_W,
    parameter int TIMEOUT_CYC = ROUTER_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 detect_add,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] status_clr,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err,
    output logic [NUM_PORTS-1:0] timeout_status
);

    localparam int NADDR = 1 << ADDR_W;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [NADDR-1:0]  full_ext;
    logic              wr_ok;

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        if (!reset) begin
            addr_d = '0;
            err_d  = 1'b0;
        end else if (detect_add) begin
            addr_d = data_in;
            err_d  = (32'(data_in) >= 32'(NUM_PORTS));
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        err_q  <= err_d;
    end

    // Widen full to the whole address space so any addr_q indexes in range.
    assign full_ext  = NADDR'(full);
    assign fifo_full = reset && !err_q && full_ext[addr_q];
    assign wr_ok     = reset && write_enb_reg && !err_q && !full_ext[addr_q];
    assign write_enb = wr_ok ? NUM_PORTS'(onehot(8'(addr_q), NUM_PORTS)) : '0;
    assign addr_err  = err_q;
    assign vld_out   = ~empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_port_timer #(
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_timer (
            .clk         (clk),
            .reset       (reset),
            .vld_i       (vld_out[i]),
            .rd_i        (read_enb[i]),
            .clr_i       (status_clr[i]),
            .soft_reset_o(soft_reset[i]),
            .status_o    (timeout_status[i])
        );
    end

endmodule

// File: doc/router_sync_nport.md
Name: router_sync_nport

Overview:
Parametrised N-output synchroniser for the 1xN router. It latches the packet destination address on header detect and steers the write enable to the selected output FIFO. It reports the full status of the selected FIFO back to the FSM, and generates per-port valid and timeout-driven soft resets. Compared with the fixed 3-port version it adds:
- configurable port count and timeout;
- out-of-range address detection;
- write gating on a full FIFO;
- sticky per-port timeout status.

Parameters:
- NUM_PORTS, 3, number of output FIFOs (2..8).
- ADDR_W, 2, width of destination address field; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT_CYC, 30, consecutive unread valid cycles before soft reset (>= 2).
- CNT_W, $clog2(TIMEOUT_CYC), localparam, per-port counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- detect_add  in  1  FSM header-detect strobe; capture address this cycle.
- data_in  in  ADDR_W  destination address (header low bits).
- write_enb_reg  in  1  FSM write-enable request.
- full  in  NUM_PORTS  per-FIFO full flags.
- empty  in  NUM_PORTS  per-FIFO empty flags.
- read_enb  in  NUM_PORTS  per-port read enables from destination.
- status_clr  in  NUM_PORTS  write-1-to-clear for timeout_status.
- write_enb  out  NUM_PORTS  one-hot FIFO write enables.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out  out  NUM_PORTS  per-port data valid.
- soft_reset  out  NUM_PORTS  per-port one-cycle FIFO flush pulse.
- addr_err  out  1  latched address is >= NUM_PORTS.
- timeout_status  out  NUM_PORTS  sticky: port has timed out since last clear.

Behaviour:
- Reset (reset==0 at edge): addr_q=0, addr_err=0, all counters=0, soft_reset=0, timeout_status=0. write_enb and fifo_full are forced 0 combinationally while reset is low.
- Address capture: when detect_add=1, addr_q<=data_in and addr_err<=(data_in>=NUM_PORTS). Otherwise both hold. addr_q is visible the cycle after detect_add.
- write_enb (combinational): one-hot bit addr_q is high only if all of the following hold: write_enb_reg=1, addr_err=0, full[addr_q]=0. In every other case write_enb is all zero.
  - Gating on full is new: no write is ever issued to a full FIFO, even if the FSM requests it.
- fifo_full (combinational): full[addr_q] when addr_err=0; 0 when addr_err=1.
- vld_out[i] = ~empty[i], purely combinational, not gated by reset.
- Per-port timeout, independent per i, priority order at each edge:
  1. reset low -> cnt=0, soft_reset=0.
  2. vld_out[i]=0 -> cnt=0, soft_reset=0.
  3. read_enb[i]=1 -> cnt=0, soft_reset=0.
  4. cnt==TIMEOUT_CYC-1 -> cnt=0, soft_reset=1, timeout_status[i]=1.
  5. Otherwise -> cnt+1, soft_reset=0.
- Timeout timing: soft_reset[i] goes high at the TIMEOUT_CYC-th edge after vld rises with no read, and stays high exactly one cycle. If the FIFO stays non-empty and unread, it re-fires every TIMEOUT_CYC cycles.
- A read on the same cycle that the terminal count is reached wins: no pulse, counter is cleared.
- timeout_status[i]: status_clr[i]=1 clears it, but a same-cycle timeout event wins (bit stays 1). Not affected by vld changes.
- Mid-packet address change: a new detect_add re-targets write_enb from the next cycle. No buffering of in-flight data.
- No combinational path from data_in to write_enb; the path is via addr_q only.

Decomposition:
- Package router_pkg holds:
  - default constants ROUTER_NUM_PORTS=3, ROUTER_ADDR_W=2, ROUTER_TIMEOUT=30;
  - function onehot(addr, n).
- One sub-module, router_port_timer: the per-port counter, soft_reset and timeout_status logic, parametrised by TIMEOUT_CYC. Instantiate it NUM_PORTS times in a generate loop.

Test Plan:
- Reset held low 3 cycles with write_enb_reg=1, data_in=1 -> write_enb=000, fifo_full=0, soft_reset=000, addr_err=0.
- detect_add with data_in=2, then write_enb_reg=1, full=000 -> write_enb=100. Then raise full[2] -> write_enb=000 and fifo_full=1 in the same cycle.
- detect_add with data_in=3 (NUM_PORTS=3), write_enb_reg=1 -> addr_err=1, write_enb=000, fifo_full=0. Then detect_add with data_in=0 -> addr_err=0, write_enb=001.
- empty[0] drops and stays low, read_enb[0]=0 -> soft_reset[0] high exactly at edge 30 for 1 cycle and timeout_status[0]=1. Continue unread -> second pulse at edge 60.
- Same as above but read_enb[0]=1 at edge 29 -> no pulse. Counter restarts, so the first pulse comes 30 cycles after the read.
- status_clr[1]=1 on the same edge as a port-1 timeout -> timeout_status[1] stays 1. status_clr[1]=1 on a later cycle -> bit clears.
